// File: rtl/afu_write_drain_if.sv
// FIFO-read and host-write channel bundle between the AFU output FIFO,
// the write drain stage and the host write channel.
interface afu_write_drain_if #(
    parameter int ADDR_WIDTH = 58
);
    logic [511:0]          fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_re;
    logic                  wr_req_valid;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic [511:0]          wr_req_data;
    logic                  wr_req_almost_full;
    logic                  wr_rsp_valid;

    // Drain stage side: pops the FIFO, issues write requests.
    modport master (
        input  fifo_dout, fifo_empty, wr_req_almost_full, wr_rsp_valid,
        output fifo_re, wr_req_valid, wr_req_addr, wr_req_data
    );

    // Environment side: FIFO and host write channel.
    modport slave (
        output fifo_dout, fifo_empty, wr_req_almost_full, wr_rsp_valid,
        input  fifo_re, wr_req_valid, wr_req_addr, wr_req_data
    );
endinterface

// File: rtl/afu_write_drain.sv
// Write drain: pops result lines from the AFU output FIFO, issues addressed
// write requests two cycles later, and tracks completions against a bounded
// outstanding window. Signals done once ctx_length lines are acknowledged.
module afu_write_drain #(
    parameter int ADDR_WIDTH      = 58,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           ctx_length,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    afu_write_drain_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  rsp_err
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [31:0]           len_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           popped_q;
    logic [31:0]           issued_q;
    logic [31:0]           acked_q;
    logic [31:0]           acked_d;
    logic [OW-1:0]         outstanding_q;
    logic [OW-1:0]         outstanding_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  rsp_err_q;
    logic                  re_q;
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [511:0]          req_data_q;
    logic                  pop;
    logic                  rsp_ok;
    logic                  start_ok;

    // Pop qualification, response acceptance and window bookkeeping.
    always_comb begin
        pop = (state_q == S_RUN) && !bus.fifo_empty && !bus.wr_req_almost_full &&
              (popped_q < len_q) && (outstanding_q < OW'(MAX_OUTSTANDING));
        rsp_ok   = bus.wr_rsp_valid && (outstanding_q != '0);
        start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        outstanding_d = outstanding_q;
        if (pop && !rsp_ok) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!pop && rsp_ok) begin
            outstanding_d = outstanding_q - OW'(1);
        end
        acked_d = acked_q + (rsp_ok ? 32'd1 : 32'd0);
    end

    // Job control FSM with counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            base_q        <= '0;
            popped_q      <= '0;
            acked_q       <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            popped_q      <= popped_q + (pop ? 32'd1 : 32'd0);
            outstanding_q <= outstanding_d;
            acked_q       <= acked_d;
            if (bus.wr_rsp_valid && (outstanding_q == '0)) begin
                rsp_err_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_q         <= ctx_length;
                        base_q        <= dst_base;
                        popped_q      <= '0;
                        acked_q       <= '0;
                        outstanding_q <= '0;
                        rsp_err_q     <= 1'b0;
                        if (ctx_length == 32'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (popped_q == len_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Uses the post-response count so done rises the cycle after the last ack.
                    if (acked_d == len_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Two-stage issue pipeline: pop strobe delay, then request register.
    always_ff @(posedge clk) begin
        if (reset) begin
            re_q        <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            issued_q    <= '0;
        end else begin
            re_q <= pop;
            if (re_q) begin
                req_valid_q <= 1'b1;
                req_data_q  <= bus.fifo_dout;
                req_addr_q  <= base_q + ADDR_WIDTH'(issued_q);
                issued_q    <= issued_q + 32'd1;
            end else begin
                req_valid_q <= 1'b0;
            end
            if (start_ok) begin
                issued_q <= '0;
            end
        end
    end

    assign bus.fifo_re      = pop;
    assign bus.wr_req_valid = req_valid_q;
    assign bus.wr_req_addr  = req_addr_q;
    assign bus.wr_req_data  = req_data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign rsp_err          = rsp_err_q;
endmodule

// File: tb/tb_afu_write_drain.sv
// Bench for afu_write_drain: table of directed jobs plus hand-written
// back-pressure, window-limit, stray-response and mid-job reset sequences.
module tb_afu_write_drain;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ctx_length = '0;
    logic [57:0] dst_base = '0;
    logic        busy, done, rsp_err;

    afu_write_drain_if #(.ADDR_WIDTH(58)) bus_if ();

    afu_write_drain #(.ADDR_WIDTH(58), .MAX_OUTSTANDING(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ctx_length (ctx_length),
        .dst_base   (dst_base),
        .bus        (bus_if.master),
        .busy       (busy),
        .done       (done),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] len;
        logic [57:0] base;
        int          dly;
        int          exp_done;
        logic [57:0] exp_last;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    // environment controls (written by the stimulus process only)
    int unsigned fifo_cnt = 0;
    int unsigned rel_total = 0;
    logic        af = 1'b0;
    logic        stray = 1'b0;
    logic        auto_rsp = 1'b0;
    int          dly = 1;
    int unsigned first_idx = 0;
    int unsigned req0 = 0;

    // environment state (written by the model processes only)
    int unsigned pop_idx = 0;
    int unsigned crd_given = 0;
    logic        crd_q = 1'b0;
    logic [15:0] rsp_pipe = '0;
    int unsigned req_total = 0;
    logic [57:0]  log_addr [0:255];
    logic [511:0] log_data [0:255];
    int unsigned  log_cyc  [0:255];

    function automatic logic [511:0] make_line(input int unsigned j);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) begin
            l[i*32 +: 32] = (j * 32'h0101_0101) ^ (32'(i) << 24) ^ 32'hC0DE_0000;
        end
        return l;
    endfunction

    assign bus_if.fifo_empty         = (pop_idx == fifo_cnt);
    assign bus_if.wr_req_almost_full = af;
    assign bus_if.wr_rsp_valid       = (auto_rsp && rsp_pipe[dly-1]) || crd_q || stray;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus_if.fifo_re) begin
            bus_if.fifo_dout <= make_line(pop_idx);
            pop_idx          <= pop_idx + 1;
        end
    end

    always @(posedge clk) begin
        rsp_pipe <= {rsp_pipe[14:0], bus_if.wr_req_valid & auto_rsp};
        if (!auto_rsp && (crd_given < rel_total)) begin
            crd_q     <= 1'b1;
            crd_given <= crd_given + 1;
        end else begin
            crd_q <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus_if.wr_req_valid) begin
            log_addr[req_total % 256] <= bus_if.wr_req_addr;
            log_data[req_total % 256] <= bus_if.wr_req_data;
            log_cyc[req_total % 256]  <= cyc;
            req_total                 <= req_total + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_job(input logic [31:0] len, input logic [57:0] base, output int unsigned s);
        ctx_length = len;
        dst_base   = base;
        start      = 1'b1;
        s          = cyc;
        first_idx  = pop_idx;
        req0       = req_total;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned s, output int unsigned off);
        while (!done && (cyc - s) < 300) step();
        off = cyc - s;
    endtask

    task automatic check_seq(input string tag, input int unsigned n, input logic [57:0] base, input bit consec);
        int unsigned errs = 0;
        int unsigned idx;
        logic [57:0] ea;
        for (int unsigned k = 0; k < n; k++) begin
            idx = (req0 + k) % 256;
            ea  = base + 58'(k);
            if (log_addr[idx] !== ea || log_data[idx] !== make_line(first_idx + k) ||
                (consec && log_cyc[idx] != log_cyc[req0 % 256] + k)) errs++;
        end
        chk({tag, "_seq"}, 64'(errs), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned s;
        int unsigned off;
        auto_rsp = 1'b1;
        dly      = v.dly;
        fifo_cnt = fifo_cnt + ((v.len == 0) ? 1 : v.len);
        step();
        start_job(v.len, v.base, s);
        chk({tag, "_busy"}, 64'(busy), 64'(v.len != 0));
        chk({tag, "_err_clr"}, 64'(rsp_err), 64'd0);
        wait_done(s, off);
        chk({tag, "_done_lat"}, 64'(off), 64'(v.exp_done));
        chk({tag, "_pops"}, 64'(pop_idx - first_idx), 64'(v.len));
        chk({tag, "_nreq"}, 64'(req_total - req0), 64'(v.len));
        if (v.len != 0) begin
            chk({tag, "_req_lat"}, 64'(log_cyc[req0 % 256] - s), 64'd3);
            chk({tag, "_last_addr"}, 64'(log_addr[(req0 + v.len - 1) % 256]), 64'(v.exp_last));
            check_seq(tag, v.len, v.base, 1'b1);
        end
        chk({tag, "_err_end"}, 64'(rsp_err), 64'd0);
    endtask

    vec_t vecs [6];

    initial begin
        int unsigned s;
        int unsigned off;
        int unsigned rel0;
        int n_a, n_b, n_c, n_d;
        logic r_a;

        vecs[0] = '{32'd4, 58'h100,                 5, 12, 58'h103};
        vecs[1] = '{32'd1, 58'h3FF,                 1, 5,  58'h3FF};
        vecs[2] = '{32'd8, 58'h2000,                1, 12, 58'h2007};
        vecs[3] = '{32'd0, 58'h55,                  1, 1,  58'h0};
        vecs[4] = '{32'd4, 58'h3FF_FFFF_FFFF_FFFE,  2, 9,  58'h1};
        vecs[5] = '{32'd3, 58'h10,                  2, 8,  58'h12};

        // reset state
        repeat (3) step();
        chk("reset_outputs", 64'({bus_if.fifo_re, bus_if.wr_req_valid, busy, done, rsp_err,
                                  |bus_if.wr_req_addr, |bus_if.wr_req_data}), 64'd0);
        reset = 1'b0;
        step();

        // stray response in IDLE
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("idle_rsp_err", 64'(rsp_err), 64'd1);
        chk("idle_state", 64'({busy, done}), 64'd0);
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // back-pressure: almost_full high in cycles 3..10 of a 16-line job
        auto_rsp = 1'b1;
        dly      = 1;
        fifo_cnt = fifo_cnt + 16;
        step();
        start_job(32'd16, 58'h4000, s);
        n_a = 0; n_b = 0; n_c = 0; r_a = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            af = (c >= 3 && c <= 10);
            #1;
            if (c >= 3 && c <= 10 && bus_if.fifo_re) n_a++;
            if (c == 11) r_a = bus_if.fifo_re;
            if (c >= 4 && c <= 5 && bus_if.wr_req_valid) n_b++;
            if (c >= 5 && c <= 12 && bus_if.wr_req_valid) n_c++;
            step();
        end
        af = 1'b0;
        wait_done(s, off);
        chk("bp_no_pop", 64'(n_a), 64'd0);
        chk("bp_resume_pop", 64'(r_a), 64'd1);
        chk("bp_req_4_5_le2", 64'(n_b <= 2), 64'd1);
        chk("bp_req_gap", 64'(n_c), 64'd0);
        chk("bp_done_lat", 64'(off), 64'd28);
        chk("bp_nreq", 64'(req_total - req0), 64'd16);
        check_seq("bp", 16, 58'h4000, 1'b0);

        // window limit: responses withheld, then released
        auto_rsp  = 1'b0;
        rel_total = crd_given;
        rel0      = rel_total;
        fifo_cnt  = fifo_cnt + 10;
        step();
        start_job(32'd10, 58'h8000, s);
        n_d = 0;
        for (int c = 1; c <= 11; c++) begin
            if (bus_if.fifo_re) n_d++;
            step();
        end
        chk("win_pops_stall", 64'(n_d), 64'd4);
        rel_total = rel_total + 1;
        n_d = 0; r_a = 1'b0;
        for (int c = 12; c <= 21; c++) begin
            if (c == 14) r_a = bus_if.fifo_re;
            if (bus_if.fifo_re) n_d++;
            step();
        end
        chk("win_one_more", 64'(n_d), 64'd1);
        chk("win_pop_at_14", 64'(r_a), 64'd1);
        while (!done && (cyc - s) < 400) begin
            if ((rel_total - rel0) < (req_total - req0)) rel_total = rel_total + 1;
            step();
        end
        chk("win_done", 64'(done), 64'd1);
        chk("win_nreq", 64'(req_total - req0), 64'd10);
        chk("win_err", 64'(rsp_err), 64'd0);
        check_seq("win", 10, 58'h8000, 1'b0);

        // reset mid-job after 3 of 8 lines popped
        rel_total = crd_given;
        fifo_cnt  = fifo_cnt + 8;
        step();
        start_job(32'd8, 58'hC000, s);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_outputs", 64'({bus_if.fifo_re, bus_if.wr_req_valid, busy, done, rsp_err,
                                    |bus_if.wr_req_addr, |bus_if.wr_req_data}), 64'd0);
        chk("rst_mid_pops", 64'(pop_idx - first_idx), 64'd3);
        reset = 1'b0;
        step();
        fifo_cnt = pop_idx;
        run_vec('{32'd8, 58'hC000, 1, 12, 58'hC007}, "rst_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
